// File: rtl/moore_rule_fsm.sv
// moore_rule_fsm
//
// Table-programmable Moore state machine. Transitions are held in a small
// register file of rules {vld, src, val, mask, dst} that is loaded at run
// time through a one-rule-per-cycle config port. On every enabled step, all
// rules are compared against the current state and input in parallel. The
// lowest-indexed matching rule selects the next state. The output is the
// state register itself, so there is no combinational path from y_in or
// cfg_* to any output.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset: state, hit, hit_idx and all rule
//             valid bits are cleared
//   en        step enable; state/hit/hit_idx change only when en=1
//   y_in      FSM input, sampled on the step edge
//   cfg_we    rule write strobe
//   cfg_addr  rule index to write (indices >= NRULES are ignored)
//   cfg_vld   valid bit of the written rule (0 deletes the rule)
//   cfg_src   source state of the rule
//   cfg_val   input pattern of the rule
//   cfg_mask  care mask of the rule (1 = bit compared)
//   cfg_dst   destination state of the rule
//   y_out     current state (registered)
//   hit       registered: last step matched a rule
//   hit_idx   registered: index of the rule that fired on the last match
module moore_rule_fsm #(
  parameter int SW          = 4,
  parameter int IW          = 4,
  parameter int NSTATES     = 16,
  parameter int NRULES      = 32,
  parameter int RESET_STATE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [IW-1:0]             y_in,
  input  logic                      cfg_we,
  input  logic [$clog2(NRULES)-1:0] cfg_addr,
  input  logic                      cfg_vld,
  input  logic [SW-1:0]             cfg_src,
  input  logic [IW-1:0]             cfg_val,
  input  logic [IW-1:0]             cfg_mask,
  input  logic [SW-1:0]             cfg_dst,
  output logic [SW-1:0]             y_out,
  output logic                      hit,
  output logic [$clog2(NRULES)-1:0] hit_idx
);

  localparam int AW = $clog2(NRULES);

  localparam logic [SW-1:0] RESET_W = SW'(RESET_STATE);
  // One bit wider than the state so that NSTATES == 2**SW is representable.
  localparam logic [SW:0] NSTATES_W = (SW+1)'(NSTATES);

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  logic [SW-1:0] state_reg;
  logic          hit_reg;
  logic [AW-1:0] hit_idx_reg;

  // ---------------------------------------------------------------------
  // Rule storage
  // ---------------------------------------------------------------------
  logic [NRULES-1:0] vld_reg;
  logic [SW-1:0]     src_reg  [NRULES];
  logic [IW-1:0]     val_reg  [NRULES];
  logic [IW-1:0]     mask_reg [NRULES];
  logic [SW-1:0]     dst_reg  [NRULES];

  // Per-rule decode
  logic [NRULES-1:0] wr_sel;
  logic [NRULES-1:0] match_vec;
  logic [NRULES-1:0] dst_ok;

  // Priority-encoder results
  logic          match_any;
  logic [AW-1:0] sel_idx;
  logic [SW-1:0] sel_dst;
  logic          sel_ok;

  generate
    for (genvar gi = 0; gi < NRULES; gi++) begin : g_rule
      // An out-of-range cfg_addr equals no gi, so such a write selects
      // nothing and leaves every rule untouched.
      assign wr_sel[gi] = cfg_we && (cfg_addr == AW'(gi));

      // Full-width compare of the source state and of the masked input.
      assign match_vec[gi] = vld_reg[gi]
                          && (src_reg[gi] == state_reg)
                          && (((y_in ^ val_reg[gi]) & mask_reg[gi]) == '0);

      // The destination legality check is the only place a state is
      // compared against NSTATES.
      assign dst_ok[gi] = ({1'b0, dst_reg[gi]} < NSTATES_W);
    end
  endgenerate

  // Valid bits are the only rule fields that need reset. A rule can only
  // become valid through a post-reset write, and that same write also
  // loads its data fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
    end else begin
      for (int r = 0; r < NRULES; r++) begin
        if (wr_sel[r]) begin
          vld_reg[r] <= cfg_vld;
        end
      end
    end
  end

  // Data fields carry no reset. A write that lands while rst_n is low only
  // touches the fields of a rule whose valid bit is being held at 0, so it
  // can never make that rule fire.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NRULES; r++) begin
      if (wr_sel[r]) begin
        src_reg[r]  <= cfg_src;
        val_reg[r]  <= cfg_val;
        mask_reg[r] <= cfg_mask;
        dst_reg[r]  <= cfg_dst;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Priority encoder
  // ---------------------------------------------------------------------
  // The scan runs from the highest index down, so the lowest-indexed
  // matching rule is the last assignment and therefore wins.
  always_comb begin
    match_any = 1'b0;
    sel_idx   = '0;
    sel_dst   = '0;
    sel_ok    = 1'b0;
    for (int r = NRULES - 1; r >= 0; r--) begin
      if (match_vec[r]) begin
        match_any = 1'b1;
        sel_idx   = AW'(r);
        sel_dst   = dst_reg[r];
        sel_ok    = dst_ok[r];
      end
    end
  end

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  // The step sees the rule registers before any write on the same edge
  // lands, so a newly written rule takes effect on the following step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RESET_W;
      hit_reg     <= 1'b0;
      hit_idx_reg <= '0;
    end else if (en) begin
      if (match_any) begin
        // An illegal destination is redirected to the reset state, so an
        // out-of-range state can never be entered.
        state_reg   <= sel_ok ? sel_dst : RESET_W;
        hit_reg     <= 1'b1;
        hit_idx_reg <= sel_idx;
      end else begin
        hit_reg     <= 1'b0;
      end
    end
  end

  assign y_out   = state_reg;
  assign hit     = hit_reg;
  assign hit_idx = hit_idx_reg;

endmodule

// File: tb/tb_moore_rule_fsm.sv
// Directed and random checks for moore_rule_fsm.
//
// Two instances share all inputs:
// - dut_a uses the default parameters (16 states, 32 rules).
// - dut_s uses 12 states and 24 rules, which lets the bench reach an
//   illegal destination and an out-of-range config address.
module tb_moore_rule_fsm;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] y_in;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic       cfg_vld;
  logic [3:0] cfg_src;
  logic [3:0] cfg_val;
  logic [3:0] cfg_mask;
  logic [3:0] cfg_dst;

  logic [3:0] a_y;
  logic       a_hit;
  logic [4:0] a_idx;
  logic [3:0] s_y;
  logic       s_hit;
  logic [4:0] s_idx;

  int checks   = 0;
  int failures = 0;

  moore_rule_fsm dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .y_in     (y_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_vld  (cfg_vld),
    .cfg_src  (cfg_src),
    .cfg_val  (cfg_val),
    .cfg_mask (cfg_mask),
    .cfg_dst  (cfg_dst),
    .y_out    (a_y),
    .hit      (a_hit),
    .hit_idx  (a_idx)
  );

  moore_rule_fsm #(
    .NSTATES (12),
    .NRULES  (24)
  ) dut_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .y_in     (y_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_vld  (cfg_vld),
    .cfg_src  (cfg_src),
    .cfg_val  (cfg_val),
    .cfg_mask (cfg_mask),
    .cfg_dst  (cfg_dst),
    .y_out    (s_y),
    .hit      (s_hit),
    .hit_idx  (s_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic v, input logic [3:0] src,
                    input logic [3:0] val, input logic [3:0] mask, input logic [3:0] dst);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_vld  = v;
    cfg_src  = src;
    cfg_val  = val;
    cfg_mask = mask;
    cfg_dst  = dst;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    $display("write rule=%0d vld=%0b src=%0d val=%b mask=%b dst=%0d", addr, v, src, val, mask, dst);
  endtask

  task automatic step(input logic [3:0] y);
    en   = 1'b1;
    y_in = y;
    @(posedge clk);
    #1;
    en = 1'b0;
    $display("step y_in=%b a:y=%0d hit=%0b idx=%0d s:y=%0d hit=%0b idx=%0d",
             y, a_y, a_hit, a_idx, s_y, s_hit, s_idx);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    $display("reset pulse");
  endtask

  initial begin
    logic [3:0] exp_s;
    logic       exp_hit;
    logic [4:0] exp_idx;
    logic       e;
    logic [3:0] y;

    rst_n = 1'b0; en = 1'b0; y_in = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_vld = 1'b0; cfg_src = '0; cfg_val = '0; cfg_mask = '0; cfg_dst = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y",   32'(a_y),   0);
    check("rst_hit", 32'(a_hit), 0);
    check("rst_idx", 32'(a_idx), 0);
    rst_n = 1'b1;

    // Don't-care mask: 1010 vs 1000 differs only in a masked-out bit.
    wr(5'd0, 1'b1, 4'd0, 4'b1000, 4'b1101, 4'd6);
    step(4'b1010);
    check("mask_y",   32'(a_y),   6);
    check("mask_hit", 32'(a_hit), 1);
    check("mask_idx", 32'(a_idx), 0);
    check("mask_s_y", 32'(s_y),   6);

    // Move on to state 5 so that reset is applied mid-run.
    wr(5'd1, 1'b1, 4'd6, 4'b0000, 4'b0000, 4'd5);
    step(4'b0000);
    check("to5_y",   32'(a_y),   5);
    check("to5_idx", 32'(a_idx), 1);

    // Asynchronous reset takes effect before any edge.
    #2 rst_n = 1'b0;
    #1;
    check("arst_y",   32'(a_y),   0);
    check("arst_hit", 32'(a_hit), 0);
    check("arst_idx", 32'(a_idx), 0);
    // A write and a step attempted while in reset must both be ignored.
    en = 1'b1; y_in = 4'b0000;
    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_vld = 1'b1; cfg_src = 4'd0;
    cfg_val = 4'b0000; cfg_mask = 4'b0000; cfg_dst = 4'd7;
    @(posedge clk);
    #1;
    check("rsthold_y", 32'(a_y), 0);
    rst_n = 1'b1; en = 1'b0; cfg_we = 1'b0;
    step(4'b0000);
    check("clr_y",   32'(a_y),   0);
    check("clr_hit", 32'(a_hit), 0);

    // Patterns that differ from the rule in a cared-for bit.
    wr(5'd0, 1'b1, 4'd0, 4'b1000, 4'b1101, 4'd6);
    step(4'b1001);
    check("nm_y",   32'(a_y),   0);
    check("nm_hit", 32'(a_hit), 0);
    step(4'b1110);
    check("nm2_y", 32'(a_y), 0);

    // Priority: rules 2 and 7 both match 1111, so rule 2 wins.
    wr(5'd2, 1'b1, 4'd0, 4'b0000, 4'b0000, 4'd3);
    wr(5'd7, 1'b1, 4'd0, 4'b1111, 4'b1111, 4'd13);
    step(4'b1111);
    check("pri_y",   32'(a_y),   3);
    check("pri_hit", 32'(a_hit), 1);
    check("pri_idx", 32'(a_idx), 2);
    check("pri_s_y", 32'(s_y),   3);
    en = 1'b0; y_in = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_y", 32'(a_y), 3);
    end
    $display("hold 10 cycles y=%0d", a_y);
    check("hold_hit", 32'(a_hit), 1);
    check("hold_idx", 32'(a_idx), 2);
    // No rule has source 3: state holds, hit clears, hit_idx holds.
    step(4'b1111);
    check("nohit_y",   32'(a_y),   3);
    check("nohit_hit", 32'(a_hit), 0);
    check("nohit_idx", 32'(a_idx), 2);

    // Destination 13 is illegal for dut_s (12 states) but legal for dut_a.
    rst_pulse();
    wr(5'd0, 1'b1, 4'd0, 4'b0000, 4'b0000, 4'd13);
    step(4'b0101);
    check("ill_s_y",   32'(s_y),   0);
    check("ill_s_hit", 32'(s_hit), 1);
    check("ill_s_idx", 32'(s_idx), 0);
    check("ill_a_y",   32'(a_y),   13);

    // Same-edge write and step: the step uses the old rule 0 (invalid).
    rst_pulse();
    wr(5'd1, 1'b1, 4'd0, 4'b0000, 4'b0000, 4'd9);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_vld = 1'b1; cfg_src = 4'd0;
    cfg_val = 4'b0000; cfg_mask = 4'b0000; cfg_dst = 4'd4;
    en = 1'b1; y_in = 4'b0000;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; en = 1'b0;
    $display("write+step a:y=%0d idx=%0d", a_y, a_idx);
    check("se_y",   32'(a_y),   9);
    check("se_idx", 32'(a_idx), 1);
    check("se_s_y", 32'(s_y),   9);
    step(4'b0000);
    check("se2_y",   32'(a_y),   9);
    check("se2_hit", 32'(a_hit), 0);

    // Address 24 is out of range for dut_s and in range for dut_a.
    rst_pulse();
    wr(5'd0, 1'b1, 4'd0, 4'b0101, 4'b1111, 4'd2);
    wr(5'd24, 1'b1, 4'd0, 4'b0000, 4'b0000, 4'd5);
    step(4'b0000);
    check("oor_s_y",   32'(s_y),   0);
    check("oor_s_hit", 32'(s_hit), 0);
    check("oor_a_y",   32'(a_y),   5);
    check("oor_a_idx", 32'(a_idx), 24);
    step(4'b0101);
    check("oor_s_y2",   32'(s_y),   2);
    check("oor_s_idx2", 32'(s_idx), 0);

    // Variant-3 table:
    // - y[3]=1       : next = (5*s+1) mod 16 (rule 2s)
    // - y[3:1]=001   : next = (s+3) mod 16   (rule 2s+1)
    // - otherwise    : hold
    rst_pulse();
    for (int s = 0; s < 16; s++) begin
      wr(5'(2*s),   1'b1, 4'(s), 4'b1000, 4'b1000, 4'((5*s+1) % 16));
      wr(5'(2*s+1), 1'b1, 4'(s), 4'b0010, 4'b1110, 4'((s+3) % 16));
    end
    exp_s = 4'd0; exp_hit = 1'b0; exp_idx = 5'd0;
    for (int i = 0; i < 10000; i++) begin
      e = ($urandom_range(0, 3) != 0);
      y = 4'($urandom_range(0, 15));
      if (e) begin
        if (y[3]) begin
          exp_idx = 5'(2 * int'(exp_s));
          exp_s   = 4'((5 * int'(exp_s) + 1) % 16);
          exp_hit = 1'b1;
        end else if (y[3:1] == 3'b001) begin
          exp_idx = 5'(2 * int'(exp_s) + 1);
          exp_s   = 4'((int'(exp_s) + 3) % 16);
          exp_hit = 1'b1;
        end else begin
          exp_hit = 1'b0;
        end
      end
      en = e; y_in = y;
      @(posedge clk);
      #1;
      check("regr", 32'({a_y, a_hit, a_idx}), 32'({exp_s, exp_hit, exp_idx}));
    end
    en = 1'b0;
    $display("regression done y=%0d", a_y);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
